// File: rtl/game_mode_ctrl.sv
// game_mode_ctrl - game-mode sequencer MENU -> INGAME -> ENDGAME -> LEADERBOARD -> MENU.
// Runs a round timer on a prescaled game tick, holds ENDGAME for a fixed number of
// ticks, and gates gameplay through ingameOn.
// Optional feature macro: GAME_PAUSE_EN (adds the PAUSED mode driven by keypause).
// Ports:
//   CLOCK_50    in   system clock, posedge
//   resetn      in   async active-low reset
//   userquit    in   return to MENU, highest priority
//   keytobegin  in   start/confirm key (level, edge detected here)
//   keypause    in   pause toggle key (level, edge detected here; unused without GAME_PAUSE_EN)
//   gameOver    in   gameplay end-of-game request (level)
//   mode        out  mode code MENU=0000 INGAME=0011 PAUSED=0100 ENDGAME=0101 LEADERBOARD=1001
//   ingameOn    out  high only in INGAME
//   hex0holder  out  HEX0 digit for the current mode
//   time_left   out  remaining round ticks
//   round_done  out  one-cycle pulse on INGAME -> ENDGAME
//
// state     | meaning
// S_MENU    | idle, waiting for a start key edge
// S_INGAME  | round running, time_left counts down per tick
// S_PAUSED  | round frozen (GAME_PAUSE_EN builds only)
// S_ENDGAME | round over, held for HOLD_TICKS ticks
// S_LEADER  | leaderboard shown, start key edge returns to MENU
module game_mode_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int ROUND_TICKS = 60,
  parameter int HOLD_TICKS  = 3,
  parameter int TIME_W      = 8
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              userquit,
  input  logic              keytobegin,
  input  logic              keypause,
  input  logic              gameOver,
  output logic [3:0]        mode,
  output logic              ingameOn,
  output logic [3:0]        hex0holder,
  output logic [TIME_W-1:0] time_left,
  output logic              round_done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [2:0] {
    S_MENU    = 3'd0,
    S_INGAME  = 3'd1,
    S_PAUSED  = 3'd2,
    S_ENDGAME = 3'd3,
    S_LEADER  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     presc, presc_nxt;
  logic [HW-1:0]     hold, hold_nxt;
  logic [TIME_W-1:0] time_nxt;
  logic              key_q;
  logic              start;
  logic              tick;
  logic              done_nxt;
  logic [3:0]        mode_nxt;
  logic [3:0]        hex_nxt;
  logic              ingame_nxt;

`ifdef GAME_PAUSE_EN
  logic pause_q;
  logic pause_edge;
  assign pause_edge = keypause & ~pause_q;
`else
  logic unused_keypause;
  assign unused_keypause = keypause;
`endif

  assign start = keytobegin & ~key_q;
  // Prescaler only advances in INGAME/ENDGAME, so the tick is qualified by state.
  assign tick  = (presc == PW'(TICK_DIV - 1)) &&
                 ((state == S_INGAME) || (state == S_ENDGAME));

  always_comb begin
    state_nxt = state;
    time_nxt  = time_left;
    hold_nxt  = hold;
    done_nxt  = 1'b0;
    if (userquit) begin
      state_nxt = S_MENU;
      time_nxt  = '0;
      hold_nxt  = '0;
    end else begin
      case (state)
        S_MENU: begin
          if (start) begin
            state_nxt = S_INGAME;
            time_nxt  = TIME_W'(ROUND_TICKS);
          end
        end
        S_INGAME: begin
          if (gameOver) begin
            state_nxt = S_ENDGAME;
            done_nxt  = 1'b1;
          end else if (tick && (time_left <= TIME_W'(1))) begin
            // <= 1 rather than == 1 so the timer can never wrap below zero
            time_nxt  = '0;
            state_nxt = S_ENDGAME;
            done_nxt  = 1'b1;
          end else begin
            if (tick) time_nxt = time_left - TIME_W'(1);
`ifdef GAME_PAUSE_EN
            if (pause_edge) state_nxt = S_PAUSED;
`endif
          end
        end
`ifdef GAME_PAUSE_EN
        S_PAUSED: begin
          if (pause_edge) state_nxt = S_INGAME;
        end
`endif
        S_ENDGAME: begin
          if (tick) begin
            if (hold == HW'(HOLD_TICKS - 1)) begin
              state_nxt = S_LEADER;
              hold_nxt  = '0;
            end else begin
              hold_nxt = hold + HW'(1);
            end
          end
        end
        S_LEADER: begin
          if (start) begin
            state_nxt = S_MENU;
            time_nxt  = '0;
          end
        end
        default: begin
          state_nxt = S_MENU;
          time_nxt  = '0;
          hold_nxt  = '0;
        end
      endcase
    end

    // Every state change restarts the tick phase; PAUSED simply keeps the count.
    if (userquit || (state_nxt != state)) presc_nxt = '0;
    else if ((state == S_INGAME) || (state == S_ENDGAME)) presc_nxt = tick ? '0 : presc + PW'(1);
    else presc_nxt = presc;

    mode_nxt   = 4'b0000;
    hex_nxt    = 4'd0;
    ingame_nxt = 1'b0;
    case (state_nxt)
      S_INGAME:  begin mode_nxt = 4'b0011; hex_nxt = 4'd1; ingame_nxt = 1'b1; end
      S_PAUSED:  begin mode_nxt = 4'b0100; hex_nxt = 4'd3; end
      S_ENDGAME: begin mode_nxt = 4'b0101; hex_nxt = 4'd2; end
      S_LEADER:  begin mode_nxt = 4'b1001; hex_nxt = 4'd4; end
      default:   begin mode_nxt = 4'b0000; hex_nxt = 4'd0; end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= S_MENU;
      presc      <= '0;
      hold       <= '0;
      key_q      <= 1'b0;
      time_left  <= '0;
      mode       <= 4'b0000;
      ingameOn   <= 1'b0;
      hex0holder <= 4'd0;
      round_done <= 1'b0;
`ifdef GAME_PAUSE_EN
      pause_q    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      hold       <= hold_nxt;
      key_q      <= keytobegin;
      time_left  <= time_nxt;
      mode       <= mode_nxt;
      ingameOn   <= ingame_nxt;
      hex0holder <= hex_nxt;
      round_done <= done_nxt;
`ifdef GAME_PAUSE_EN
      pause_q    <= keypause;
`endif
    end
  end

endmodule
